// File: rtl/arbitro_escritura_banco.sv
// arbitro_escritura_banco: round-robin write arbiter for a register bank with a full-bank clear sequence.
module arbitro_escritura_banco #(
  parameter int ANCHO_DATO = 16,
  parameter int ANCHO_DIR  = 3
) (
  input  logic                  Reloj,
  input  logic                  Reiniciar,
  input  logic [2:0]            Solicitud,
  input  logic [ANCHO_DATO-1:0] Dato0,
  input  logic [ANCHO_DATO-1:0] Dato1,
  input  logic [ANCHO_DATO-1:0] Dato2,
  input  logic [ANCHO_DIR-1:0]  Dir0,
  input  logic [ANCHO_DIR-1:0]  Dir1,
  input  logic [ANCHO_DIR-1:0]  Dir2,
  input  logic                  Limpiar,
  output logic [2:0]            Concedido,
  output logic                  HabilitarEscritura,
  output logic [ANCHO_DIR-1:0]  DireccionEscritura,
  output logic [ANCHO_DATO-1:0] DatoEscritura,
  output logic                  Listo
);
  typedef enum logic {LIMPIAR, SERVIR} estado_t;
  estado_t estado;
  logic [ANCHO_DIR-1:0] contador;
  logic [1:0] ultimo, p0, p1, sel;
  logic [2:0] elegible;
  always_comb begin
    elegible = Solicitud & ~Concedido;
    p0 = ultimo == 2'd2 ? 2'd0 : ultimo + 2'd1;
    p1 = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
    sel = elegible[p0] ? p0 : elegible[p1] ? p1 : ultimo;
  end
  always_ff @(posedge Reloj or posedge Reiniciar)
    if (Reiniciar) begin
      estado <= LIMPIAR;
      contador <= '0;
      ultimo <= 2'd2;
      Concedido <= '0;
      HabilitarEscritura <= 1'b0;
      DireccionEscritura <= '0;
      DatoEscritura <= '0;
      Listo <= 1'b0;
    end else if (estado == LIMPIAR) begin
      HabilitarEscritura <= 1'b1;
      DireccionEscritura <= contador;
      DatoEscritura <= '0;
      Concedido <= '0;
      Listo <= 1'b0;
      contador <= contador + 1'b1;
      if (&contador) estado <= SERVIR;
    end else if (Limpiar) begin
      estado <= LIMPIAR;
      contador <= '0;
      Concedido <= '0;
      HabilitarEscritura <= 1'b0;
      Listo <= 1'b0;
    end else begin
      Listo <= 1'b1;
      HabilitarEscritura <= |elegible;
      Concedido <= |elegible ? 3'b001 << sel : 3'b000;
      if (|elegible) begin
        ultimo <= sel;
        DireccionEscritura <= sel == 2'd0 ? Dir0 : sel == 2'd1 ? Dir1 : Dir2;
        DatoEscritura <= sel == 2'd0 ? Dato0 : sel == 2'd1 ? Dato1 : Dato2;
      end
    end
endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// tb_arbitro_escritura_banco: directed and random checks of the bank write arbiter against a behavioural model.
module tb_arbitro_escritura_banco;
  logic Reloj = 1'b0, Reiniciar = 1'b1, Limpiar = 1'b0;
  logic [2:0] Solicitud = '0;
  logic [15:0] Dato0 = '0, Dato1 = '0, Dato2 = '0;
  logic [2:0] Dir0 = '0, Dir1 = '0, Dir2 = '0;
  logic [2:0] Concedido;
  logic HabilitarEscritura, Listo;
  logic [2:0] DireccionEscritura;
  logic [15:0] DatoEscritura;

  arbitro_escritura_banco #(.ANCHO_DATO(16), .ANCHO_DIR(3)) dut (
    .Reloj(Reloj), .Reiniciar(Reiniciar), .Solicitud(Solicitud),
    .Dato0(Dato0), .Dato1(Dato1), .Dato2(Dato2),
    .Dir0(Dir0), .Dir1(Dir1), .Dir2(Dir2), .Limpiar(Limpiar),
    .Concedido(Concedido), .HabilitarEscritura(HabilitarEscritura),
    .DireccionEscritura(DireccionEscritura), .DatoEscritura(DatoEscritura), .Listo(Listo)
  );

  always #5 Reloj = ~Reloj;

  int compared = 0, mismatched = 0;
  // Model: clearing flag, next clear address, last granted, and what the bank sees this cycle.
  int mClear, mCnt, mLast, mGnt, mEn, mAddr, mData, mListo;

  task automatic modelReset();
    mClear = 1; mCnt = 0; mLast = 2; mGnt = -1; mEn = 0; mAddr = 0; mData = 0; mListo = 0;
  endtask

  task automatic modelEdge();
    int g = -1;
    if (mClear != 0) begin
      mEn = 1; mAddr = mCnt; mData = 0; mGnt = -1; mListo = 0;
      if (mCnt == 7) mClear = 0;
      mCnt = (mCnt + 1) % 8;
    end else if (Limpiar) begin
      mClear = 1; mCnt = 0; mGnt = -1; mEn = 0; mListo = 0;
    end else begin
      mListo = 1;
      for (int k = 1; k <= 3; k++) begin
        int i = (mLast + k) % 3;
        if (g < 0 && Solicitud[i] && i != mGnt) g = i;
      end
      mGnt = g;
      mEn = g >= 0 ? 1 : 0;
      if (g >= 0) begin
        mLast = g;
        mAddr = g == 0 ? int'(Dir0) : g == 1 ? int'(Dir1) : int'(Dir2);
        mData = g == 0 ? int'(Dato0) : g == 1 ? int'(Dato1) : int'(Dato2);
      end
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
    end
  endtask

  task automatic cmpModel();
    logic [2:0] g = mGnt < 0 ? 3'b000 : 3'b001 << mGnt;
    chk("model", {8'd0, Concedido, HabilitarEscritura, DireccionEscritura, DatoEscritura, Listo},
        {8'd0, g, mEn[0], mAddr[2:0], mData[15:0], mListo[0]});
  endtask

  task automatic step();
    modelEdge();
    @(posedge Reloj);
    @(negedge Reloj);
    cmpModel();
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
  task automatic doReset();
    Reiniciar = 1'b1;
    #1;
    modelReset();
    chk("reset_outputs", {8'd0, Concedido, HabilitarEscritura, DireccionEscritura, DatoEscritura, Listo}, 32'd0);
    cmpModel();
    Reiniciar = 1'b0;
  endtask

  initial begin
    logic [2:0] gnts[4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [2:0] dirs[4] = '{3'd1, 3'd2, 3'd3, 3'd1};
    @(negedge Reloj);
    doReset();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("clear_addr", DireccionEscritura, i);
      chk("clear_en", HabilitarEscritura, 1);
      chk("clear_data", DatoEscritura, 0);
    end
    step();
    chk("ready_after_clear", {Listo, HabilitarEscritura}, 2'b10);

    Solicitud = 3'b111; Dir0 = 3'd1; Dir1 = 3'd2; Dir2 = 3'd3;
    Dato0 = 16'hAAAA; Dato1 = 16'hBBBB; Dato2 = 16'hCCCC;
    doReset();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("no_grant_in_clear", Concedido, 0);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_grant", Concedido, gnts[i]);
      chk("rr_addr", DireccionEscritura, dirs[i]);
    end
    chk("rr_data", DatoEscritura, 16'hAAAA);

    Solicitud = 3'b101;
    step(); chk("skip_to_2", Concedido, 3'b100);
    step(); chk("back_to_0", Concedido, 3'b001);

    Solicitud = 3'b010;
    step(); chk("single_grant", Concedido, 3'b010);
    step(); chk("single_gap", {Concedido, HabilitarEscritura}, 4'b0000);
    step(); chk("single_regrant", Concedido, 3'b010);

    Solicitud = 3'b001; Limpiar = 1'b1;
    step(); chk("clear_wins", {Concedido, HabilitarEscritura, Listo}, 5'b00000);
    Limpiar = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("reclear", {Concedido, HabilitarEscritura, DireccionEscritura}, {3'b000, 1'b1, 3'(i)});
    end
    step(); chk("grant_after_reclear", {Concedido, Listo}, 4'b0011);

    Solicitud = 3'b000;
    doReset();
    for (int i = 0; i < 5; i++) step();
    chk("mid_clear_addr", DireccionEscritura, 4);
    doReset();
    step(); chk("restart_addr", {HabilitarEscritura, DireccionEscritura}, 4'b1000);

    for (int n = 0; n < 3000; n++) begin
      Solicitud = 3'($urandom);
      Dato0 = 16'($urandom); Dato1 = 16'($urandom); Dato2 = 16'($urandom);
      Dir0 = 3'($urandom); Dir1 = 3'($urandom); Dir2 = 3'($urandom);
      Limpiar = $urandom_range(0, 29) == 0;
      if ($urandom_range(0, 199) == 0) doReset();
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/arbitro_escritura_banco.md
ARBITRO_ESCRITURA_BANCO -- requirements
Module: arbitro_escritura_banco

Interface
REQ-001 Parameter ANCHO_DATO, default 16, data width of the register bank write port.
REQ-002 Parameter ANCHO_DIR, default 3, address width; the bank holds 2**ANCHO_DIR registers.
REQ-003 The block SHALL use a single clock and an asynchronous, active-high reset.
REQ-004 Reloj  input  1  clock; all state changes on the rising edge.
REQ-005 Reiniciar  input  1  asynchronous, active-high reset.
REQ-006 Solicitud  input  3  write request per requester; bit i belongs to requester i.
REQ-007 Dato0, Dato1, Dato2  input  ANCHO_DATO each  write data of requesters 0..2.
REQ-008 Dir0, Dir1, Dir2  input  ANCHO_DIR each  target register of requesters 0..2.
REQ-009 Limpiar  input  1  single-cycle pulse requesting a clear of the whole bank.
REQ-010 Concedido  output  3  one-hot grant; bit i high for exactly one cycle per serviced write.
REQ-011 HabilitarEscritura  output  1  bank write enable.
REQ-012 DireccionEscritura  output  ANCHO_DIR  bank write address.
REQ-013 DatoEscritura  output  ANCHO_DATO  bank write data.
REQ-014 Listo  output  1  high when the bank is initialised and requests are being served.

Function
REQ-015 All outputs SHALL be registered; the bank samples them at the rising edge that ends the cycle in which they are valid.
REQ-016 FSM states SHALL be LIMPIAR and SERVIR only.
REQ-017 LIMPIAR SHALL issue one write per cycle: addresses 0, 1, ..., 2**ANCHO_DIR-1 in order, DatoEscritura=0, HabilitarEscritura=1, Concedido=0.
REQ-018 After address 2**ANCHO_DIR-1 is issued, the FSM SHALL go to SERVIR and Listo SHALL be 1 from the next cycle.
REQ-019 In LIMPIAR, Solicitud SHALL be ignored; requesters keep their requests pending.
REQ-020 In SERVIR, for each edge with at least one eligible request, the block SHALL grant exactly one requester in round-robin order, starting after the last granted index (Ultimo).
REQ-021 On a grant to requester i, the next cycle SHALL show Concedido[i]=1, HabilitarEscritura=1, DireccionEscritura=Dir i, DatoEscritura=Dato i (all sampled at the granting edge), and Ultimo SHALL become i.
REQ-022 A requester whose Concedido bit is high in the current cycle SHALL NOT be eligible at the edge ending that cycle; a single requester is therefore granted at most every other cycle.
REQ-023 With no eligible request, HabilitarEscritura and Concedido SHALL be 0; DireccionEscritura/DatoEscritura SHALL hold their last values.
REQ-024 Limpiar=1 in SERVIR SHALL win over any Solicitud at that edge: no grant; the next cycle enters LIMPIAR with Listo=0 and the address counter at 0.
REQ-025 Limpiar in LIMPIAR SHALL be ignored; the clear does not restart.
REQ-026 Grant-to-write latency SHALL be 1 cycle and is fixed; no back-pressure from the bank exists.

Reset
REQ-027 While Reiniciar=1: state LIMPIAR, address counter 0, Ultimo=2 (requester 0 has first priority), Concedido=0, HabilitarEscritura=0, DireccionEscritura=0, DatoEscritura=0, Listo=0.
REQ-028 Reiniciar asserted mid-clear or mid-grant SHALL abort immediately; any partially cleared bank is fully cleared again after release.
REQ-029 The first clear write (address 0) SHALL appear in the cycle after the first rising edge following release of Reiniciar.

Verification
REQ-030 Reset release, no requests -> 8 consecutive cycles of HabilitarEscritura=1 with addresses 0..7 and data 0, then Listo=1 and HabilitarEscritura=0.
REQ-031 Solicitud=3'b111 held from reset release, Dir0/1/2=1/2/3, Dato=16'hAAAA/16'hBBBB/16'hCCCC -> no grant during clear; then grants 0,1,2,0,... one per cycle with matching address/data.
REQ-032 Only Solicitud[1] held continuously in SERVIR -> Concedido=3'b010 every other cycle, with a gap cycle where HabilitarEscritura=0.
REQ-033 Limpiar pulse together with Solicitud=3'b001 in SERVIR -> no grant, Listo falls next cycle, 8 clear writes follow, then requester 0 is granted.
REQ-034 Reiniciar pulse during clear address 4 -> outputs return to reset values asynchronously; after release the clear restarts at address 0.
REQ-035 Solicitud=3'b101 after a grant to requester 0 -> requester 2 granted next, then requester 0.
